// File: rtl/bcd_stopwatch.sv
// BCD mm:ss stopwatch advanced by rising edges of a synchronized slow_clk.
// Optional lap-freeze of the displayed digits: define STOPWATCH_LAP_EN.
module bcd_stopwatch #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock_in,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       rollover
);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;
  logic                   count_en;
  logic                   wrap;

  logic [3:0] s1_q, s1_n;
  logic [2:0] s10_q, s10_n;
  logic [3:0] m1_q, m1_n;
  logic [2:0] m10_q, m10_n;

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick     = sync_q[SYNC_STAGES-1] & ~prev_q;
  // The tick is judged against the state before any same-cycle toggle.
  assign count_en = tick & (state == RUNNING) & ~clear;

  always_comb begin
    state_next = state;
    if (clear)
      state_next = STOPPED;
    else if (start_stop)
      state_next = (state == RUNNING) ? STOPPED : RUNNING;
  end

  always_comb begin
    s1_n  = s1_q;
    s10_n = s10_q;
    m1_n  = m1_q;
    m10_n = m10_q;
    wrap  = 1'b0;
    if (s1_q != 4'd9) begin
      s1_n = s1_q + 4'd1;
    end else begin
      s1_n = '0;
      if (s10_q != 3'd5) begin
        s10_n = s10_q + 3'd1;
      end else begin
        s10_n = '0;
        if (m1_q != 4'd9) begin
          m1_n = m1_q + 4'd1;
        end else begin
          m1_n = '0;
          if (m10_q != 3'd5) begin
            m10_n = m10_q + 3'd1;
          end else begin
            m10_n = '0;
            wrap  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STOPPED;
      running  <= 1'b0;
      rollover <= 1'b0;
      s1_q     <= '0;
      s10_q    <= '0;
      m1_q     <= '0;
      m10_q    <= '0;
    end else begin
      state    <= state_next;
      running  <= (state_next == RUNNING);
      rollover <= count_en & wrap;
      if (clear) begin
        s1_q  <= '0;
        s10_q <= '0;
        m1_q  <= '0;
        m10_q <= '0;
      end else if (count_en) begin
        s1_q  <= s1_n;
        s10_q <= s10_n;
        m1_q  <= m1_n;
        m10_q <= m10_n;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic       hold_q, hold_n;
  logic       capture;
  logic [3:0] f_s1_q, f_m1_q;
  logic [2:0] f_s10_q, f_m10_q;

  always_comb begin
    hold_n  = hold_q;
    capture = 1'b0;
    if (clear) begin
      hold_n = 1'b0;
    end else if (start_stop && state == RUNNING) begin
      hold_n = 1'b0;
    end else if (lap) begin
      if (hold_q) begin
        hold_n = 1'b0;
      end else if (state == RUNNING) begin
        hold_n  = 1'b1;
        capture = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= 1'b0;
      f_s1_q  <= '0;
      f_s10_q <= '0;
      f_m1_q  <= '0;
      f_m10_q <= '0;
    end else begin
      hold_q <= hold_n;
      if (capture) begin
        f_s1_q  <= s1_q;
        f_s10_q <= s10_q;
        f_m1_q  <= m1_q;
        f_m10_q <= m10_q;
      end
    end
  end

  assign sec_ones = hold_q ? f_s1_q  : s1_q;
  assign sec_tens = hold_q ? f_s10_q : s10_q;
  assign min_ones = hold_q ? f_m1_q  : m1_q;
  assign min_tens = hold_q ? f_m10_q : m10_q;
`else
  logic lap_unused;
  assign lap_unused = lap;

  assign sec_ones = s1_q;
  assign sec_tens = s10_q;
  assign min_ones = m1_q;
  assign min_tens = m10_q;
`endif

endmodule
